// File: rtl/laa_pkg.sv
// laa_pkg: shared opcode, decode constants, command and FSM state types for the LAA sequencer
package laa_pkg;
   typedef enum logic [1:0] {
      LAA_NONE     = 2'd0,
      LAA_READ     = 2'd1,
      LAA_WRITE    = 2'd2,
      LAA_MULTIPLY = 2'd3
   } laa_opcode_e;
   localparam logic [6:0] LAA_CUSTOM_OPC = 7'b0001011;
   localparam logic [4:0] LAA_F_WRITE = 5'b00010;
   localparam logic [4:0] LAA_F_READ  = 5'b00001;
   localparam logic [4:0] LAA_F_MUL   = 5'b00011;
   typedef struct packed {
      laa_opcode_e op;
      logic [4:0]  laa_reg;
      logic [4:0]  core_rd;
      logic [31:0] data;
   } laa_cmd_t;
   typedef logic [2:0] laa_seq_state_t;
   localparam laa_seq_state_t S_IDLE      = 3'd0;
   localparam laa_seq_state_t S_ISSUE_WR  = 3'd1;
   localparam laa_seq_state_t S_ISSUE_RD  = 3'd2;
   localparam laa_seq_state_t S_CAP_RD    = 3'd3;
   localparam laa_seq_state_t S_ISSUE_MUL = 3'd4;
   localparam laa_seq_state_t S_POLL_RD   = 3'd5;
   localparam laa_seq_state_t S_POLL_CHK  = 3'd6;
endpackage

// File: rtl/laa_cmd_sequencer_if.sv
// laa_cmd_sequencer_if: core instruction, LAA bus and writeback signals of the sequencer
interface laa_cmd_sequencer_if;
   import laa_pkg::*;
   logic        ins_valid;
   logic [31:0] ins;
   logic [31:0] rs1_data;
   logic        ins_ready;
   logic        stall;
   logic        busy;
   laa_opcode_e laa_opcode;
   logic [4:0]  laa_addr;
   logic [31:0] laa_data_in;
   logic [31:0] laa_data_out;
   logic        wb_valid;
   logic [4:0]  wb_rd;
   logic [31:0] wb_data;
   logic        err_illegal;
   logic        err_timeout;
   modport slave (
      input  ins_valid, ins, rs1_data, laa_data_out,
      output ins_ready, stall, busy, laa_opcode, laa_addr, laa_data_in,
             wb_valid, wb_rd, wb_data, err_illegal, err_timeout
   );
   modport master (
      output ins_valid, ins, rs1_data, laa_data_out,
      input  ins_ready, stall, busy, laa_opcode, laa_addr, laa_data_in,
             wb_valid, wb_rd, wb_data, err_illegal, err_timeout
   );
endinterface

// File: rtl/laa_cmd_fifo.sv
// laa_cmd_fifo: in-order command FIFO; caller never pushes when full nor pops when empty
module laa_cmd_fifo
   import laa_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic     clk,
   input  logic     rst,
   input  logic     push,
   input  logic     pop,
   input  laa_cmd_t din,
   output laa_cmd_t dout,
   output logic     full,
   output logic     empty
);
   localparam int AW = $clog2(DEPTH);
   laa_cmd_t mem [DEPTH];
   logic [AW:0] wp, rp;
   assign empty = wp == rp;
   assign full  = wp == {~rp[AW], rp[AW-1:0]};
   assign dout  = mem[rp[AW-1:0]];
   always_ff @(posedge clk) begin
      if (push) mem[wp[AW-1:0]] <= din;
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wp <= '0;
         rp <= '0;
      end else begin
         if (push) wp <= wp + (AW+1)'(1);
         if (pop) rp <= rp + (AW+1)'(1);
      end
   end
endmodule

// File: rtl/laa_cmd_sequencer.sv
// laa_cmd_sequencer: decodes LAA instructions into a FIFO and issues them in order on the LAA bus
module laa_cmd_sequencer
   import laa_pkg::*;
#(
   parameter int         FIFO_DEPTH   = 4,
   parameter int         POLL_TIMEOUT = 1024,
   parameter logic [4:0] DONE_REG     = 5'd31
) (
   input logic clk,
   input logic Rst,
   laa_cmd_sequencer_if.slave bus
);
   localparam int CW = $clog2(POLL_TIMEOUT + 1);
   laa_seq_state_t state;
   laa_cmd_t       cur, head, dec;
   logic [CW-1:0]  cnt;
   logic [4:0]     funct;
   logic           full, empty, legal, accept, push, pop, unused_ins;
   assign funct      = bus.ins[11:7];
   assign unused_ins = ^bus.ins[21:12];
   assign legal      = bus.ins[6:0] == LAA_CUSTOM_OPC &&
                       (funct == LAA_F_WRITE || funct == LAA_F_READ || funct == LAA_F_MUL);
   assign bus.ins_ready = !full && !Rst;
   assign bus.stall     = bus.ins_valid && !bus.ins_ready && !Rst;
   assign accept        = bus.ins_valid && bus.ins_ready;
   assign push          = accept && legal;
   assign pop           = state == S_IDLE && !empty;
   assign bus.busy      = !empty || state != S_IDLE;
   always_comb begin
      dec.op      = funct == LAA_F_WRITE ? LAA_WRITE : funct == LAA_F_READ ? LAA_READ : LAA_MULTIPLY;
      dec.laa_reg = funct == LAA_F_READ ? bus.ins[31:27] : bus.ins[26:22];
      dec.core_rd = bus.ins[26:22];
      dec.data    = bus.rs1_data;
   end
   laa_cmd_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk   (clk),
      .rst   (Rst),
      .push  (push),
      .pop   (pop),
      .din   (dec),
      .dout  (head),
      .full  (full),
      .empty (empty)
   );
   // bus outputs decode straight from the state register so they are clean for one cycle
   assign bus.laa_opcode  = state == S_ISSUE_WR ? LAA_WRITE :
                            (state == S_ISSUE_RD || state == S_POLL_RD) ? LAA_READ :
                            state == S_ISSUE_MUL ? LAA_MULTIPLY : LAA_NONE;
   assign bus.laa_addr    = (state == S_ISSUE_WR || state == S_ISSUE_RD) ? cur.laa_reg :
                            state == S_POLL_RD ? DONE_REG : 5'd0;
   assign bus.laa_data_in = state == S_ISSUE_WR ? cur.data : 32'd0;
   always_ff @(posedge clk or posedge Rst) begin
      if (Rst) begin
         state           <= S_IDLE;
         cur             <= '0;
         cnt             <= '0;
         bus.wb_valid    <= 1'b0;
         bus.wb_rd       <= 5'd0;
         bus.wb_data     <= 32'd0;
         bus.err_illegal <= 1'b0;
         bus.err_timeout <= 1'b0;
      end else begin
         bus.wb_valid    <= 1'b0;
         bus.err_timeout <= 1'b0;
         bus.err_illegal <= accept && !legal;
         case (state)
            S_IDLE: begin
               if (!empty) begin
                  cur   <= head;
                  state <= head.op == LAA_WRITE ? S_ISSUE_WR : head.op == LAA_READ ? S_ISSUE_RD : S_ISSUE_MUL;
               end
            end
            S_ISSUE_WR: state <= S_IDLE;
            S_ISSUE_RD: state <= S_CAP_RD;
            S_CAP_RD: begin
               bus.wb_valid <= 1'b1;
               bus.wb_rd    <= cur.core_rd;
               bus.wb_data  <= bus.laa_data_out;
               state        <= S_IDLE;
            end
            S_ISSUE_MUL: begin
               cnt   <= '0;
               state <= S_POLL_RD;
            end
            S_POLL_RD: state <= S_POLL_CHK;
            S_POLL_CHK: begin
               if (bus.laa_data_out != 32'd0) begin
                  state <= S_IDLE;
               end else if (cnt == CW'(POLL_TIMEOUT - 1)) begin
                  bus.err_timeout <= 1'b1;
                  state           <= S_IDLE;
               end else begin
                  cnt   <= cnt + CW'(1);
                  state <= S_POLL_RD;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_laa_cmd_sequencer.sv
// tb_laa_cmd_sequencer: directed checks of laa_cmd_sequencer against an LAA register-file model
module tb_laa_cmd_sequencer;
   import laa_pkg::*;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;
   laa_cmd_sequencer_if bus();
   laa_cmd_sequencer #(.FIFO_DEPTH(4), .POLL_TIMEOUT(8), .DONE_REG(5'd31)) dut (
      .clk (clk),
      .Rst (rst),
      .bus (bus)
   );
   int checks = 0;
   int failures = 0;
   int cyc = 0;
   int done_at = 32'h7fffffff;
   logic [31:0] regs [32];
   int          ev_cyc [$];
   logic [1:0]  ev_op [$];
   logic [4:0]  ev_addr [$];
   logic [31:0] ev_data [$];
   int          wb_cyc [$];
   logic [4:0]  wb_rd_q [$];
   logic [31:0] wb_data_q [$];
   int n_ill, n_to, to_cyc;
   bit saw_stall;
   localparam logic [31:0] INS_MUL = {20'd0, LAA_F_MUL, LAA_CUSTOM_OPC};
   function automatic logic [31:0] enc_wr(input logic [4:0] r);
      return {5'd0, r, 10'd0, LAA_F_WRITE, LAA_CUSTOM_OPC};
   endfunction
   function automatic logic [31:0] enc_rd(input logic [4:0] r, input logic [4:0] rd);
      return {r, rd, 10'd0, LAA_F_READ, LAA_CUSTOM_OPC};
   endfunction
   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask
   // LAA model: WRITE stores, READ returns data next cycle, reg 31 reports done from done_at on
   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (bus.laa_opcode == LAA_WRITE) regs[bus.laa_addr] <= bus.laa_data_in;
      if (bus.laa_opcode == LAA_READ)
         bus.laa_data_out <= bus.laa_addr == 5'd31 ? 32'(cyc >= done_at) : regs[bus.laa_addr];
   end
   always @(negedge clk) begin
      if (!rst) begin
         if (bus.laa_opcode != LAA_NONE) begin
            ev_cyc.push_back(cyc);
            ev_op.push_back(bus.laa_opcode);
            ev_addr.push_back(bus.laa_addr);
            ev_data.push_back(bus.laa_data_in);
         end
         if (bus.wb_valid) begin
            wb_cyc.push_back(cyc);
            wb_rd_q.push_back(bus.wb_rd);
            wb_data_q.push_back(bus.wb_data);
         end
         if (bus.err_illegal) n_ill++;
         if (bus.err_timeout) begin
            n_to++;
            to_cyc = cyc;
         end
         if (bus.ins_valid && bus.stall) saw_stall = 1'b1;
      end
   end
   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask
   task automatic clear();
      ev_cyc.delete(); ev_op.delete(); ev_addr.delete(); ev_data.delete();
      wb_cyc.delete(); wb_rd_q.delete(); wb_data_q.delete();
      n_ill = 0; n_to = 0; to_cyc = 0; saw_stall = 1'b0;
   endtask
   task automatic send(input logic [31:0] w, input logic [31:0] d, output int acc);
      int n = 0;
      bus.ins_valid = 1'b1;
      bus.ins = w;
      bus.rs1_data = d;
      while (!bus.ins_ready && n < 200) begin
         tick(1);
         n++;
      end
      if (n >= 200) check("accept_wait", 1, 0);
      acc = cyc;
      tick(1);
      bus.ins_valid = 1'b0;
   endtask
   task automatic wait_idle();
      int n = 0;
      while (bus.busy && n < 300) begin
         tick(1);
         n++;
      end
      check("idle_wait", n < 300, 1);
      tick(3);
   endtask
   initial begin
      int a, b, m, k, nw;
      logic [4:0]  w_addr [3];
      logic [31:0] w_dat [3];
      logic [31:0] words [6];
      logic [31:0] wdata [6];
      for (int i = 0; i < 32; i++) regs[i] = 32'd0;
      bus.ins_valid = 1'b0;
      bus.ins = 32'd0;
      bus.rs1_data = 32'd0;
      bus.laa_data_out = 32'd0;
      clear();
      tick(3);
      check("rst_ins_ready", bus.ins_ready, 0);
      check("rst_busy", bus.busy, 0);
      check("rst_opcode", bus.laa_opcode, LAA_NONE);
      check("rst_wb_valid", bus.wb_valid, 0);
      check("rst_errs", {bus.err_illegal, bus.err_timeout, bus.stall}, 0);
      rst = 1'b0;
      #1;
      check("post_rst_ready", bus.ins_ready, 1);
      tick(1);
      // WRITE then READ of LAA reg 2
      clear();
      send(32'h0880010B, 32'hDEADBEEF, a);
      wait_idle();
      check("wr_count", ev_op.size(), 1);
      check("wr_op", ev_op[0], LAA_WRITE);
      check("wr_addr", ev_addr[0], 2);
      check("wr_data", ev_data[0], 32'hDEADBEEF);
      check("wr_cycle", ev_cyc[0], a + 2);
      clear();
      send(32'h1100008B, 32'd0, b);
      wait_idle();
      check("rd_count", ev_op.size(), 1);
      check("rd_op", ev_op[0], LAA_READ);
      check("rd_addr", ev_addr[0], 2);
      check("rd_cycle", ev_cyc[0], b + 2);
      check("rd_wb_count", wb_cyc.size(), 1);
      check("rd_wb_cycle", wb_cyc[0], b + 4);
      check("rd_wb_rd", wb_rd_q[0], 4);
      check("rd_wb_data", wb_data_q[0], 32'hDEADBEEF);
      // MULTIPLY completing after 10 cycles, READ queued behind it
      clear();
      send(INS_MUL, 32'd0, m);
      done_at = m + 12;
      send(enc_rd(5'd2, 5'd5), 32'd0, b);
      wait_idle();
      check("mul_ev_count", ev_op.size(), 8);
      check("mul_op", ev_op[0], LAA_MULTIPLY);
      check("mul_cycle", ev_cyc[0], m + 2);
      for (k = 0; k < 6; k++)
         check($sformatf("poll%0d", k), {ev_op[1+k], ev_addr[1+k], 32'(ev_cyc[1+k])},
               {LAA_READ, 5'd31, 32'(m + 3 + 2*k)});
      check("mul_next_rd", {ev_op[7], ev_addr[7], 32'(ev_cyc[7])}, {LAA_READ, 5'd2, 32'(m + 16)});
      check("mul_no_timeout", n_to, 0);
      check("mul_wb", {wb_rd_q[0], wb_data_q[0], 32'(wb_cyc[0])}, {5'd5, 32'hDEADBEEF, 32'(m + 18)});
      // MULTIPLY that never completes
      clear();
      done_at = 32'h7fffffff;
      send(INS_MUL, 32'd0, m);
      wait_idle();
      check("to_ev_count", ev_op.size(), 9);
      nw = 0;
      for (int i = 0; i < ev_op.size(); i++) if (ev_op[i] == LAA_READ && ev_addr[i] == 5'd31) nw++;
      check("to_polls", nw, 8);
      check("to_last_poll", ev_cyc[8], m + 17);
      check("to_pulses", n_to, 1);
      check("to_cycle", to_cyc, m + 19);
      check("to_idle", bus.busy, 0);
      // six instructions queued behind a long MULTIPLY
      clear();
      words = '{enc_wr(5'd3), enc_rd(5'd3, 5'd6), enc_wr(5'd7), enc_rd(5'd7, 5'd7), enc_wr(5'd3), enc_rd(5'd3, 5'd8)};
      wdata = '{32'hA1A1A1A1, 32'd0, 32'hB2B2B2B2, 32'd0, 32'hC3C3C3C3, 32'd0};
      send(INS_MUL, 32'd0, m);
      for (int i = 0; i < 6; i++) send(words[i], wdata[i], a);
      wait_idle();
      check("bb_stall", saw_stall, 1);
      check("bb_timeout", n_to, 1);
      nw = 0;
      for (int i = 0; i < ev_op.size(); i++)
         if (ev_op[i] == LAA_WRITE && nw < 3) begin
            w_addr[nw] = ev_addr[i];
            w_dat[nw] = ev_data[i];
            nw++;
         end
      check("bb_writes", nw, 3);
      check("bb_wr_order", {w_addr[0], w_addr[1], w_addr[2]}, {5'd3, 5'd7, 5'd3});
      check("bb_wr_data2", w_dat[2], 32'hC3C3C3C3);
      check("bb_wb_count", wb_cyc.size(), 3);
      check("bb_wb0", {wb_rd_q[0], wb_data_q[0]}, {5'd6, 32'hA1A1A1A1});
      check("bb_wb1", {wb_rd_q[1], wb_data_q[1]}, {5'd7, 32'hB2B2B2B2});
      check("bb_wb2", {wb_rd_q[2], wb_data_q[2]}, {5'd8, 32'hC3C3C3C3});
      // illegal instructions
      clear();
      send(32'h00000133, 32'd0, a);
      check("ill_pulse0", bus.err_illegal, 1);
      send(32'h0000038B, 32'd0, b);
      check("ill_pulse1", bus.err_illegal, 1);
      tick(1);
      check("ill_clear", bus.err_illegal, 0);
      tick(4);
      check("ill_count", n_ill, 2);
      check("ill_no_ops", ev_op.size(), 0);
      check("ill_busy", bus.busy, 0);
      // reset in the middle of polling with two READs queued
      clear();
      send(INS_MUL, 32'd0, m);
      send(enc_rd(5'd2, 5'd10), 32'd0, a);
      send(enc_rd(5'd2, 5'd11), 32'd0, a);
      tick(4);
      check("mid_busy", bus.busy, 1);
      check("mid_polling", bus.laa_opcode, LAA_READ);
      rst = 1'b1;
      #1;
      check("mid_rst_opcode", bus.laa_opcode, LAA_NONE);
      check("mid_rst_addr", bus.laa_addr, 0);
      check("mid_rst_busy", bus.busy, 0);
      check("mid_rst_outs", {bus.wb_valid, bus.err_timeout, bus.err_illegal, bus.ins_ready}, 0);
      tick(2);
      rst = 1'b0;
      clear();
      tick(10);
      check("post_rst_no_ops", ev_op.size(), 0);
      check("post_rst_no_wb", wb_cyc.size(), 0);
      send(enc_rd(5'd2, 5'd9), 32'd0, b);
      wait_idle();
      check("post_rst_wb_count", wb_cyc.size(), 1);
      check("post_rst_wb", {wb_rd_q[0], wb_data_q[0], 32'(wb_cyc[0])}, {5'd9, 32'hDEADBEEF, 32'(b + 4)});
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1);
   end
endmodule

// File: doc/laa_cmd_sequencer.md
Name: laa_cmd_sequencer

Overview:
Sequences custom LAA instructions from the core pipeline onto the LAA register/compute port. Decodes accepted instructions into commands and buffers them in an in-order FIFO. Issues each command as a WRITE, READ or MULTIPLY opcode on LAA_bus. After a MULTIPLY, polls the LAA done register and returns READ results to the core writeback path. Sits between the core decode stage / hazard unit and the LAA instance, and replaces ad-hoc busy logic with an explicit handshake.

Parameters:
FIFO_DEPTH, 4, command FIFO entries (power of 2, >=2)
POLL_TIMEOUT, 1024, max poll cycles per MULTIPLY before abort
DONE_REG, 5'd31, LAA register polled for MULTIPLY completion (nonzero = done)

Ports:
clk  in  1  core clock
Rst  in  1  reset, asynchronous, active-high
ins_valid  in  1  core presents an LAA instruction
ins  in  32  instruction word
rs1_data  in  32  core regfile data for the WRITE source register
ins_ready  out  1  instruction accepted this cycle when ins_valid&&ins_ready
stall  out  1  core stall request = ins_valid && !ins_ready
busy  out  1  FIFO non-empty or FSM not IDLE
laa_opcode  out  2  LAA_opcode to LAA_bus.opcode
laa_addr  out  5  LAA register address
laa_data_in  out  32  write data to LAA
laa_data_out  in  32  LAA read data, valid the cycle after READ is driven
wb_valid  out  1  one-cycle writeback pulse to core
wb_rd  out  5  core destination register
wb_data  out  32  writeback data
err_illegal  out  1  one-cycle pulse: accepted instruction was illegal
err_timeout  out  1  one-cycle pulse: MULTIPLY poll timed out

Behaviour:
- Reset (async, Rst=1): FIFO empty, FSM IDLE, poll counter 0. All outputs 0; laa_opcode=NONE; ins_ready=1 after release.
- Decode at accept:
  - ins[6:0] must be 7'b0001011.
  - ins[11:7]=00010 -> WRITE, laa_reg=ins[26:22], data=rs1_data.
  - 00001 -> READ, laa_reg=ins[31:27], core_rd=ins[26:22].
  - 00011 -> MULTIPLY.
  - Anything else is illegal: consumed, not enqueued, err_illegal pulses the next cycle.
- ins_ready = !fifo_full. If accept and pop happen in the same cycle, both occur.
- FSM states:
  - IDLE: if FIFO non-empty, pop the head and register the opcode outputs next cycle. WRITE -> ISSUE_WR, READ -> ISSUE_RD, MULTIPLY -> ISSUE_MUL.
  - ISSUE_WR: laa_opcode=WRITE, laa_addr, laa_data_in driven for exactly 1 cycle -> IDLE.
  - ISSUE_RD: laa_opcode=READ, laa_addr driven 1 cycle -> CAP_RD.
  - CAP_RD: sample laa_data_out. Next cycle wb_valid=1, wb_rd, wb_data registered -> IDLE.
  - ISSUE_MUL: laa_opcode=MULTIPLY for 1 cycle, poll counter cleared -> POLL_RD.
  - POLL_RD: laa_opcode=READ, laa_addr=DONE_REG -> POLL_CHK.
  - POLL_CHK: if laa_data_out!=0 -> IDLE. Else if counter==POLL_TIMEOUT-1, pulse err_timeout -> IDLE. Else increment counter -> POLL_RD.
- laa_opcode=NONE, laa_addr=0, laa_data_in=0 in every state not listed as driving them.
- Latency from an empty FIFO:
  - Accept at cycle 0 -> opcode driven at cycle 2 (pop at 1).
  - READ wb_valid at cycle 4.
- Commands execute strictly in order; WRITE/READ after a MULTIPLY wait for done or timeout.
- No stall of writeback: the core must accept wb_valid unconditionally.
- Mid-operation reset aborts everything and drops the FIFO contents; no writeback is produced.

Decomposition:
- laa_pkg holds:
  - LAA_opcode enum (NONE=0, READ=1, WRITE=2, MULTIPLY=3)
  - LAA_CUSTOM_OPC=7'b0001011
  - LAA_F_WRITE/LAA_F_READ/LAA_F_MUL funct constants
  - laa_cmd_t struct {op, laa_reg[4:0], core_rd[4:0], data[31:0]}
  - laa_seq_state_t enum
- Sub-module laa_cmd_fifo: parameterised synchronous FIFO of laa_cmd_t with push/pop/full/empty and async reset.

Test Plan:
- Reset mid-POLL with FIFO holding 2 entries -> all outputs 0 immediately, busy=0, subsequent READ executes normally.
- WRITE ins=0x0880010B (laa_reg=2) with rs1_data=0xDEADBEEF, then READ ins=0x1100008B (laa_reg=2, rd=4) -> WRITE cycle at laa_addr=2 with data 0xDEADBEEF, then wb_valid with wb_rd=4, wb_data=model value for reg 2, 4 cycles after READ accept when FIFO empty.
- MULTIPLY, LAA model sets reg31=1 after 10 cycles -> alternating READ addr 31, sequencer returns IDLE on first nonzero, no err_timeout; a queued READ issues right after.
- MULTIPLY with POLL_TIMEOUT=8, reg31 stays 0 -> exactly 8 poll READs, err_timeout pulses once, FSM IDLE.
- 6 back-to-back instructions during a long MULTIPLY with FIFO_DEPTH=4 -> ins_ready=0/stall=1 once full, no loss or reorder, all drain in order.
- ins[6:0]=0x33 and funct 00111 -> err_illegal pulse each, nothing enqueued, laa_opcode stays NONE.
